// File: rtl/pito_uart_txq_if.sv
// Handshake bundle between the core-side producer, the transmit queue and the UART.
// The slave modport is the queue's view; the master modport is the surrounding system.
interface pito_uart_txq_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          uart_wr;
    logic [7:0]    uart_data;
    logic          uart_busy;
    logic [LW-1:0] level;
    logic          empty;
    logic          idle;

    modport master (
        output in_valid, in_data, uart_busy,
        input  in_ready, uart_wr, uart_data, level, empty, idle
    );

    modport slave (
        input  in_valid, in_data, uart_busy,
        output in_ready, uart_wr, uart_data, level, empty, idle
    );
endinterface

// File: rtl/pito_uart_txq.sv
// Byte FIFO feeding the pito UART transmitter through its wr/tx_data/busy interface.
// Optional LF -> CR LF expansion is enabled by defining PITO_UART_TXQ_CRLF_EN.
module pito_uart_txq #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    pito_uart_txq_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_WAIT} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          uart_wr_q;
    logic [7:0]    uart_data_q;

    logic          full;
    logic          empty;
    logic          push;
    logic          issue;
    logic          pop;
    logic [7:0]    head;
    logic [7:0]    send_byte;

`ifdef PITO_UART_TXQ_CRLF_EN
    logic          crlf_pending;
    logic          cr_first;
`endif

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    // Full is taken from the registered level, so a pop never frees a slot in the same cycle.
    assign push  = bus.in_valid && !full;
    assign issue = (state == S_IDLE) && !empty && !bus.uart_busy;
    assign head  = mem[rd_ptr];

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        send_byte = head;
        pop       = issue;
`ifdef PITO_UART_TXQ_CRLF_EN
        cr_first  = (head == 8'h0A) && !crlf_pending;
        if (cr_first) begin
            send_byte = 8'h0D;
            pop       = 1'b0;
        end
`endif
    end

    // NOTE: the byte storage has no reset; the pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            uart_wr_q   <= 1'b0;
            uart_data_q <= 8'h00;
`ifdef PITO_UART_TXQ_CRLF_EN
            crlf_pending <= 1'b0;
`endif
        end else begin
            uart_wr_q <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase

            case (state)
                S_IDLE: begin
                    if (issue) begin
                        uart_wr_q   <= 1'b1;
                        uart_data_q <= send_byte;
                        state       <= S_HOLD;
`ifdef PITO_UART_TXQ_CRLF_EN
                        crlf_pending <= cr_first;
`endif
                    end
                end
                // UART raises busy only one cycle after it sees wr; skip that blind cycle.
                S_HOLD:  state <= S_WAIT;
                S_WAIT: begin
                    if (!bus.uart_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = !full;
    assign bus.uart_wr   = uart_wr_q;
    assign bus.uart_data = uart_data_q;
    assign bus.level     = level_q;
    assign bus.empty     = empty;
    assign bus.idle      = empty && (state == S_IDLE) && !bus.uart_busy;
endmodule
